// File: rtl/select_arbiter_pkg.sv
// Shared types and default sizing for the select arbiter.
//   arb_state_t      : FSM state encoding (IDLE / GRANT / GAP)
//   DEFAULT_NUM_REQ  : default requester count
//   DEFAULT_MAX_HOLD : default tenure limit for timeout builds
//   HOLD_CNT_W       : width of the tenure hold counter
package select_arbiter_pkg;

    localparam int unsigned DEFAULT_NUM_REQ  = 8;
    localparam int unsigned DEFAULT_MAX_HOLD = 15;
    localparam int unsigned HOLD_CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage : select_arbiter_pkg

// File: rtl/select_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at last_owner+1, wrapping NUM_REQ-1 -> 0, and
// returns the first set bit. last_owner itself is checked last.
//   req        : request vector
//   last_owner : index of the most recent owner
//   valid      : at least one request is set
//   index      : chosen requester (last_owner when nothing is set)
module rr_pick #(
    parameter int unsigned NUM_REQ   = 8,
    parameter int unsigned WIDTH_SEL = 3
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [WIDTH_SEL-1:0] last_owner,
    output logic                 valid,
    output logic [WIDTH_SEL-1:0] index
);

    logic [WIDTH_SEL-1:0] cand;

    // NUM_REQ is a power of two, so the WIDTH_SEL truncation is the modulo wrap
    always_comb begin
        valid = 1'b0;
        index = last_owner;
        cand  = last_owner;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = last_owner + WIDTH_SEL'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/select_arbiter.sv
// Round-robin select arbiter with one-hot active-low select outputs.
// A tenure runs IDLE -> GRANT -> GAP -> IDLE; GAP is a one-cycle turnaround.
// Optional macro SELECT_ARB_TIMEOUT_EN bounds a tenure to MAX_HOLD cycles.
//   Clk       : rising-edge clock
//   Clear_bar : asynchronous active-low reset
//   Req       : level-held request, one bit per requester
//   Enable    : low blocks new grants and ends the current tenure
//   Y_bar     : active-low one-hot select (registered)
//   Grant_A   : encoded current/last owner (registered)
//   Busy      : high while in GRANT (registered)
//   Gap       : high during the turnaround cycle (registered)
module select_arbiter
    import select_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int unsigned WIDTH_SEL = $clog2(NUM_REQ),
    parameter int unsigned MAX_HOLD  = DEFAULT_MAX_HOLD
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic                 Enable,
    output logic [NUM_REQ-1:0]   Y_bar,
    output logic [WIDTH_SEL-1:0] Grant_A,
    output logic                 Busy,
    output logic                 Gap
);

    arb_state_t           state_q,   state_d;
    logic [WIDTH_SEL-1:0] owner_q,   owner_d;
    logic [WIDTH_SEL-1:0] grant_a_q, grant_a_d;
    logic [NUM_REQ-1:0]   y_bar_q,   y_bar_d;
    logic                 busy_q,    busy_d;
    logic                 gap_q,     gap_d;

    logic                 pick_valid;
    logic [WIDTH_SEL-1:0] pick_index;
    logic                 hold_expired_c;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH_SEL (WIDTH_SEL)
    ) u_rr_pick (
        .req        (Req),
        .last_owner (owner_q),
        .valid      (pick_valid),
        .index      (pick_index)
    );

`ifdef SELECT_ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Current GRANT cycle is the MAX_HOLD-th of this tenure
    assign hold_expired_c = (hold_cnt_q == HOLD_CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic unused_max_hold;

    // Tenure is unbounded; MAX_HOLD has no effect in this build
    assign hold_expired_c  = 1'b0;
    assign unused_max_hold = ^HOLD_CNT_W'(MAX_HOLD);
`endif

    // Next-state, owner tracking and registered-output decode
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_a_d = grant_a_q;
`ifdef SELECT_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (Enable && pick_valid) begin
                    state_d   = GRANT;
                    owner_d   = pick_index;
                    grant_a_d = pick_index;
`ifdef SELECT_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (!Req[owner_q] || !Enable || hold_expired_c) begin
                    state_d = GAP;
                end else begin
`ifdef SELECT_ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
`endif
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the next state so they are flop outputs, never decoded glitches
        busy_d  = (state_d == GRANT);
        gap_d   = (state_d == GAP);
        y_bar_d = '1;
        if (state_d == GRANT) begin
            y_bar_d[owner_d] = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state_q   <= IDLE;
            owner_q   <= WIDTH_SEL'(NUM_REQ - 1);
            grant_a_q <= '0;
            y_bar_q   <= '1;
            busy_q    <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_a_q <= grant_a_d;
            y_bar_q   <= y_bar_d;
            busy_q    <= busy_d;
            gap_q     <= gap_d;
        end
    end

    assign Y_bar   = y_bar_q;
    assign Grant_A = grant_a_q;
    assign Busy    = busy_q;
    assign Gap     = gap_q;

endmodule : select_arbiter

// File: tb/tb_select_arbiter.sv
// Self-checking bench for select_arbiter: behavioural model plus directed
// scenarios and randomized traffic. Honours SELECT_ARB_TIMEOUT_EN.
module tb_select_arbiter;

    localparam int N           = 8;
    localparam int TB_MAX_HOLD = 4;

    logic         Clk = 1'b0;
    logic         Clear_bar;
    logic [N-1:0] Req;
    logic         Enable;
    logic [N-1:0] Y_bar;
    logic [2:0]   Grant_A;
    logic         Busy;
    logic         Gap;

    int n_checks = 0;
    int n_fail   = 0;

    select_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (TB_MAX_HOLD)
    ) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .Req       (Req),
        .Enable    (Enable),
        .Y_bar     (Y_bar),
        .Grant_A   (Grant_A),
        .Busy      (Busy),
        .Gap       (Gap)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] sel_bar(input int i);
        logic [N-1:0] v;
        v    = '1;
        v[i] = 1'b0;
        return v;
    endfunction

    function automatic bit timeout_hit(input int held);
`ifdef SELECT_ARB_TIMEOUT_EN
        return held >= TB_MAX_HOLD;
`else
        return (held < 0);
`endif
    endfunction

    // Behavioural model: owner = -1 when nobody is selected
    int m_owner   = -1;
    bit m_gap     = 1'b0;
    int m_last    = N - 1;
    int m_grant_a = 0;
    int m_held    = 0;

    always @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            m_owner   = -1;
            m_gap     = 1'b0;
            m_last    = N - 1;
            m_grant_a = 0;
            m_held    = 0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (!Req[m_owner] || !Enable || timeout_hit(m_held)) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else if (Enable && Req != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (Req[(m_last + k) % N]) begin
                    m_owner   = (m_last + k) % N;
                    m_last    = m_owner;
                    m_grant_a = m_owner;
                    m_held    = 0;
                    break;
                end
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    logic [N-1:0] exp_y;
    always @(negedge Clk) begin
        exp_y = (m_owner >= 0) ? sel_bar(m_owner) : '1;
        check("model_y_bar",   Y_bar,   exp_y);
        check("model_busy",    Busy,    m_owner >= 0);
        check("model_gap",     Gap,     m_gap);
        check("model_grant_a", Grant_A, m_grant_a);
        check("onehot_y_bar",  $countones(~Y_bar) <= 1, 1);
        check("busy_vs_y_bar", Busy,    Y_bar != '1);
    end

    // Wait for Busy with a cycle budget; cyc = -1 on timeout
    task automatic wait_busy(output int cyc);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge Clk);
            cyc++;
            if (Busy) return;
        end
        cyc = -1;
    endtask

    int cyc;
    int hold;

    initial begin
        Clear_bar = 1'b1;
        Req       = '0;
        Enable    = 1'b0;
        #1 Clear_bar = 1'b0;
        repeat (2) @(negedge Clk);

        // Reset state
        check("rst_y_bar",   Y_bar,   8'hFF);
        check("rst_grant_a", Grant_A, 0);
        check("rst_busy",    Busy,    0);
        check("rst_gap",     Gap,     0);
        Clear_bar = 1'b1;
        Enable    = 1'b1;
        @(negedge Clk);
        check("idle_no_req", Busy, 0);

        // Round-robin through all owners, each tenure ended by dropping its bit
        Req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            wait_busy(cyc);
            check("rr_latency", cyc, (t == 0) ? 1 : 2);
            check("rr_owner",   Grant_A, t % 8);
            check("rr_y_bar",   Y_bar, sel_bar(t % 8));
            Req[t % 8] = 1'b0;
            @(negedge Clk);
            check("rr_gap",       Gap,   1);
            check("rr_gap_y_bar", Y_bar, 8'hFF);
            check("rr_gap_hold",  Grant_A, t % 8);
            Req = (t == 8) ? 8'h00 : 8'hFF;
        end

        // Wrap: last owner 6, requests 6 and 0 -> search goes 7 -> 0
        @(negedge Clk);
        Req = 8'h40;
        wait_busy(cyc);
        check("wrap_setup_owner", Grant_A, 6);
        Req = 8'h01;
        @(negedge Clk);
        check("wrap_gap", Gap, 1);
        Req = 8'h41;
        wait_busy(cyc);
        check("wrap_owner", Grant_A, 0);
        check("wrap_y_bar", Y_bar, 8'hFE);

        // Enable dropped mid-tenure of owner 3
        Req = 8'h00;
        repeat (2) @(negedge Clk);
        Req = 8'h08;
        wait_busy(cyc);
        check("en_owner", Grant_A, 3);
        Enable = 1'b0;
        @(negedge Clk);
        check("en_gap", Gap, 1);
        repeat (4) begin
            @(negedge Clk);
            check("en_idle_y_bar", Y_bar, 8'hFF);
            check("en_idle_busy",  Busy,  0);
        end
        Req    = 8'h00;
        Enable = 1'b1;

        // Async reset mid-GRANT, then first arbitration after release
        Req = 8'h01;
        wait_busy(cyc);
        check("rst_pre_y_bar", Y_bar, sel_bar(Grant_A == 3'd0 ? 0 : Grant_A));
        #2 Clear_bar = 1'b0;
        #1;
        check("rst_async_y_bar", Y_bar, 8'hFF);
        check("rst_async_busy",  Busy,  0);
        check("rst_async_gap",   Gap,   0);
        @(negedge Clk);
        Clear_bar = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_first_arb", Y_bar, 8'hFE);

        // Timeout: Req=03 from fresh reset, owner 0 first
        Req = 8'h00;
        #2 Clear_bar = 1'b0;
        @(negedge Clk);
        Clear_bar = 1'b1;
        Req = 8'h03;
        wait_busy(cyc);
        check("to_owner0", Grant_A, 0);
        hold = 0;
        while (Y_bar[0] == 1'b0 && hold < 30) begin
            hold++;
            @(negedge Clk);
        end
`ifdef SELECT_ARB_TIMEOUT_EN
        check("to_hold_cycles", hold, TB_MAX_HOLD);
        check("to_gap", Gap, 1);
        @(negedge Clk);
        @(negedge Clk);
        check("to_owner1", Grant_A, 1);
        check("to_busy1",  Busy, 1);
`else
        check("no_to_hold_cycles", hold, 30);
        check("no_to_owner0", Grant_A, 0);
`endif

        // Randomized traffic with occasional enable drops and resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 3) == 0) Req = N'($urandom);
            Enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 Clear_bar = 1'b0;
                @(negedge Clk);
                Clear_bar = 1'b1;
            end
        end

        @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_select_arbiter

// File: doc/select_arbiter.md
SELECT_ARBITER -- requirements
Module: select_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, number of requesters/select lines; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter WIDTH_SEL, default $clog2(NUM_REQ), encoded grant width.
REQ-003 SHALL have parameter MAX_HOLD, default 15, the maximum number of GRANT cycles per tenure (timeout builds only); legal values are 1..255.
REQ-004 Clk  input  1  single clock, rising-edge.
REQ-005 Clear_bar  input  1  reset, asynchronous, active-low.
REQ-006 Req  input  NUM_REQ  active-high request, one bit per requester, level-held.
REQ-007 Enable  input  1  global enable; low blocks new grants and ends the current tenure.
REQ-008 Y_bar  output  NUM_REQ  active-low one-hot select; at most one bit is low.
REQ-009 Grant_A  output  WIDTH_SEL  encoded index of the current or last owner.
REQ-010 Busy  output  1  high while in GRANT.
REQ-011 Gap  output  1  high during the turnaround cycle.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and GAP; all outputs are registered.
REQ-013 IDLE: if Enable=1 and any Req bit is set, the FSM enters GRANT on the next edge, with the owner chosen by round-robin; otherwise it stays in IDLE.
REQ-014 Round-robin search order SHALL start at (last_owner+1) mod NUM_REQ and wrap at NUM_REQ-1 -> 0; last_owner resets to NUM_REQ-1, so requester 0 wins first.
REQ-015 Latency: Req sampled high in IDLE -> Y_bar[owner]=0 and Busy=1 exactly one cycle later.
REQ-016 GRANT: Y_bar[owner]=0, Grant_A=owner, Busy=1; GRANT holds while Req[owner]=1 and Enable=1.
REQ-017 GRANT -> GAP on the first edge where Req[owner]=0 or Enable=0.
REQ-018 GAP lasts exactly one cycle: all Y_bar=1, Busy=0, Gap=1, Grant_A holds the previous owner; then the FSM enters IDLE.
REQ-019 Back-to-back requesters SHALL therefore see at least one dead cycle plus one arbitration cycle between selects.
REQ-020 Changes on non-owner Req bits during GRANT SHALL have no effect.
REQ-021 Enable=0 in IDLE SHALL hold IDLE with all Y_bar=1, regardless of Req.
REQ-022 Y_bar SHALL never drive two bits low, including during state transitions.

Reset
REQ-023 Clear_bar=0 SHALL immediately (asynchronously) force: state IDLE, Y_bar all 1, Grant_A 0, Busy 0, Gap 0, last_owner NUM_REQ-1, hold counter 0.
REQ-024 Reset asserted mid-GRANT SHALL release the select without passing through GAP.
REQ-025 After Clear_bar rises, the first arbitration SHALL occur on the first edge with Enable=1 and Req non-zero.

Configuration
REQ-026 Macro SELECT_ARB_TIMEOUT_EN: when defined, an 8-bit hold counter clears on GRANT entry and increments each GRANT cycle.
REQ-027 On reaching MAX_HOLD GRANT cycles, the FSM SHALL enter GAP even if Req[owner]=1; the owner becomes last in round-robin order.
REQ-028 Without SELECT_ARB_TIMEOUT_EN: no counter is present, tenure is unbounded, and MAX_HOLD is ignored.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/GRANT/GAP) and the default NUM_REQ/MAX_HOLD constants.
REQ-030 The round-robin priority picker SHALL be a combinational sub-module rr_pick (inputs Req and last_owner; outputs valid and index).
REQ-031 Y_bar SHALL be decoded from the registered owner index, gated by the GRANT state.

Verification
REQ-032 Reset: Clear_bar=0 mid-GRANT with Req=8'h01 -> Y_bar=8'hFF in the same cycle; after release with Req=8'h01 -> Y_bar=8'hFE one cycle after the first sampling edge.
REQ-033 Round-robin: Req=8'hFF held, each tenure ended by toggling the owner's bit low -> owners 0,1,2,...,7,0 in order, each followed by one Gap=1 cycle.
REQ-034 Wrap: last_owner=6 with Req=8'h41 -> next owner is 0 (search 7 -> 0), not 6.
REQ-035 Enable: Enable dropped during GRANT of owner 3 -> GAP next edge, then IDLE held with Y_bar=8'hFF while Enable=0 despite Req=8'h08.
REQ-036 Timeout (SELECT_ARB_TIMEOUT_EN, MAX_HOLD=4): Req=8'h03 held -> owner 0 low for exactly 4 cycles, Gap for 1, then owner 1; without the macro, owner 0 holds indefinitely.
REQ-037 Every scenario: assertion that at most one Y_bar bit is low and that Busy equals (Y_bar != all-ones).
